// File: rtl/demux8_nibble_collector_pkg.sv
// Shared sizing, state encoding and slot-packing helper for the nibble collector.
package demux_pkg;

    localparam int unsigned DEF_WIDTH    = 4;
    localparam int unsigned DEF_CHANNELS = 8;
    localparam int unsigned DEF_PTR_W    = $clog2(DEF_CHANNELS);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    // Bit offset of a slot inside a flattened bank.
    function automatic int unsigned slot_lsb(input int unsigned slot, input int unsigned w);
        return slot * w;
    endfunction

endpackage

// File: rtl/demux8_nibble_collector_if.sv
// Nibble input stream plus parallel frame output handshake.
interface demux8_nibble_collector_if #(
    parameter int unsigned WIDTH    = demux_pkg::DEF_WIDTH,
    parameter int unsigned CHANNELS = demux_pkg::DEF_CHANNELS,
    parameter int unsigned PTR_W    = demux_pkg::DEF_PTR_W
);
    logic [WIDTH-1:0]          din;
    logic                      din_valid;
    logic                      din_ready;
    logic                      resync;
    logic [PTR_W-1:0]          slot_idx;
    logic [CHANNELS*WIDTH-1:0] q;
    logic                      q_valid;
    logic                      q_ack;
    logic                      frame_drop;

    modport slave (
        input  din, din_valid, resync, q_ack,
        output din_ready, slot_idx, q, q_valid, frame_drop
    );

    modport master (
        output din, din_valid, resync, q_ack,
        input  din_ready, slot_idx, q, q_valid, frame_drop
    );
endinterface

// File: rtl/demux8_nibble_collector_slot_bank.sv
// CHANNELS x WIDTH register array: one indexed write port, full parallel read.
module demux8_nibble_collector_slot_bank
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned CHANNELS = DEF_CHANNELS,
    parameter int unsigned PTR_W    = DEF_PTR_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      we,
    input  logic [PTR_W-1:0]          waddr,
    input  logic [WIDTH-1:0]          wdata,
    output logic [CHANNELS*WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [CHANNELS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            rdata[slot_lsb(i, WIDTH) +: WIDTH] = mem[i];
        end
    end

endmodule

// File: rtl/demux8_nibble_collector.sv
// Collects a nibble stream into CHANNELS-slot frames; shadow bank feeds a
// registered output bank with valid/ack, HOLD when the output bank is busy.
module demux8_nibble_collector
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned CHANNELS = DEF_CHANNELS,
    parameter int unsigned PTR_W    = DEF_PTR_W
) (
    input  logic                     clk,
    input  logic                     reset,
    demux8_nibble_collector_if.slave bus
);

    localparam int unsigned      BUS_W = CHANNELS * WIDTH;
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(CHANNELS - 1);

    state_t           state, state_next;
    logic [PTR_W-1:0] slot_q, slot_next;
    logic [BUS_W-1:0] q_r, q_next, shadow;
    logic             q_valid_r, q_valid_next;
    logic             drop_r, drop_next;
    logic             sh_we;
    logic             ready_c, accept, bank_free;

    assign ready_c   = !reset && (state == COLLECT);
    assign accept    = bus.din_valid && ready_c;
    assign bank_free = !q_valid_r || bus.q_ack;

    demux8_nibble_collector_slot_bank #(
        .WIDTH(WIDTH), .CHANNELS(CHANNELS), .PTR_W(PTR_W)
    ) u_shadow (
        .clk   (clk),
        .reset (reset),
        .we    (sh_we),
        .waddr (slot_q),
        .wdata (bus.din),
        .rdata (shadow)
    );

    // Next-state, slot pointer, output bank and shadow write decode.
    always_comb begin
        state_next   = state;
        slot_next    = slot_q;
        q_next       = q_r;
        q_valid_next = q_valid_r;
        drop_next    = 1'b0;
        sh_we        = 1'b0;

        if (q_valid_r && bus.q_ack) begin
            q_valid_next = 1'b0;
        end

        case (state)
            COLLECT: begin
                if (bus.resync) begin
                    slot_next = '0;
                end else if (accept) begin
                    if (slot_q != LAST) begin
                        sh_we     = 1'b1;
                        slot_next = slot_q + PTR_W'(1);
                    end else begin
                        slot_next = '0;
                        if (bank_free) begin
                            // Final nibble bypasses the shadow straight into q.
                            q_next = shadow;
                            q_next[slot_lsb(CHANNELS - 1, WIDTH) +: WIDTH] = bus.din;
                            q_valid_next = 1'b1;
                        end else begin
                            sh_we      = 1'b1;
                            state_next = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (bus.resync) begin
                    drop_next  = 1'b1;
                    slot_next  = '0;
                    state_next = COLLECT;
                end else if (bus.q_ack) begin
                    q_next       = shadow;
                    q_valid_next = 1'b1;
                    state_next   = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= COLLECT;
            slot_q    <= '0;
            q_r       <= '0;
            q_valid_r <= 1'b0;
            drop_r    <= 1'b0;
        end else begin
            state     <= state_next;
            slot_q    <= slot_next;
            q_r       <= q_next;
            q_valid_r <= q_valid_next;
            drop_r    <= drop_next;
        end
    end

    assign bus.din_ready  = ready_c;
    assign bus.slot_idx   = slot_q;
    assign bus.q          = q_r;
    assign bus.q_valid    = q_valid_r;
    assign bus.frame_drop = drop_r;

endmodule

// File: tb/tb_demux8_nibble_collector.sv
// Scenario bench for demux8_nibble_collector with a frame scoreboard.
module tb_demux8_nibble_collector;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;
    logic [31:0] exp_q[$];

    demux8_nibble_collector_if #(.WIDTH(4), .CHANNELS(8), .PTR_W(3)) bus ();

    demux8_nibble_collector dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Sends 8 nibbles, first from order[31:28]; expected q places first nibble in slot 0.
    task automatic send_frame(input logic [31:0] order, input logic ack_last);
        logic [31:0] expf;
        for (int i = 0; i < 8; i++) begin
            bus.din       = order[28-4*i +: 4];
            expf[4*i +: 4] = order[28-4*i +: 4];
            bus.din_valid = 1'b1;
            bus.q_ack     = ack_last && (i == 7);
            cyc();
        end
        bus.din_valid = 1'b0;
        bus.q_ack     = 1'b0;
        exp_q.push_back(expf);
    endtask

    function automatic logic [31:0] pop_exp();
        if (exp_q.size() == 0) return 'x;
        return exp_q.pop_front();
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        cyc();
        cyc();
        vectors++;
        if (bus.q !== 32'h0 || bus.q_valid !== 1'b0 || bus.slot_idx !== 3'd0 ||
            bus.frame_drop !== 1'b0 || bus.din_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: q=%h qv=%b slot=%0d drop=%b rdy=%b, want 0/0/0/0/0",
                     bus.q, bus.q_valid, bus.slot_idx, bus.frame_drop, bus.din_ready);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (bus.din_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready: got %b want 1", bus.din_ready);
        end
    endtask

    task automatic test_basic();
        logic [31:0] e;
        for (int i = 0; i < 3; i++) begin
            bus.din = 4'(i + 1); bus.din_valid = 1'b1; cyc();
        end
        bus.din_valid = 1'b0;
        vectors++;
        if (bus.slot_idx !== 3'd3) begin
            miscompares++;
            $display("FAIL basic_slot_mid: got %0d want 3", bus.slot_idx);
        end
        // restart cleanly for the full frame
        bus.resync = 1'b1; cyc(); bus.resync = 1'b0;
        send_frame(32'h12345678, 1'b0);
        e = pop_exp();
        vectors++;
        if (bus.q !== e || bus.q_valid !== 1'b1 || bus.slot_idx !== 3'd0) begin
            miscompares++;
            $display("FAIL basic_frame: q=%h qv=%b slot=%0d, want q=%h qv=1 slot=0",
                     bus.q, bus.q_valid, bus.slot_idx, e);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] e;
        send_frame(32'hABCDEF09, 1'b0);
        vectors++;
        if (bus.din_ready !== 1'b0 || bus.q !== 32'h87654321 || bus.q_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_hold: rdy=%b q=%h qv=%b, want rdy=0 q=87654321 qv=1",
                     bus.din_ready, bus.q, bus.q_valid);
        end
        bus.q_ack = 1'b1;
        #1;
        vectors++;
        if (bus.din_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_ready_during_ack: got %b want 0", bus.din_ready);
        end
        cyc();
        bus.q_ack = 1'b0;
        e = pop_exp();
        vectors++;
        if (bus.q !== e || bus.q_valid !== 1'b1 || bus.din_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release: q=%h qv=%b rdy=%b, want q=%h qv=1 rdy=1",
                     bus.q, bus.q_valid, bus.din_ready, e);
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] e;
        send_frame(32'h11111113, 1'b1);
        e = pop_exp();
        vectors++;
        if (bus.q !== e || bus.q_valid !== 1'b1 || bus.din_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL simul_load: q=%h qv=%b rdy=%b, want q=%h qv=1 rdy=1",
                     bus.q, bus.q_valid, bus.din_ready, e);
        end
        bus.q_ack = 1'b1; cyc(); bus.q_ack = 1'b0;
        vectors++;
        if (bus.q_valid !== 1'b0 || bus.q !== 32'h31111111) begin
            miscompares++;
            $display("FAIL simul_ack_clear: qv=%b q=%h, want qv=0 q=31111111", bus.q_valid, bus.q);
        end
    endtask

    task automatic test_resync_mid();
        logic [31:0] e;
        for (int i = 0; i < 3; i++) begin
            bus.din = 4'h9; bus.din_valid = 1'b1; cyc();
        end
        bus.din = 4'h5; bus.resync = 1'b1;
        #1;
        vectors++;
        if (bus.din_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL resync_ready: got %b want 1", bus.din_ready);
        end
        cyc();
        bus.resync = 1'b0; bus.din_valid = 1'b0;
        vectors++;
        if (bus.slot_idx !== 3'd0) begin
            miscompares++;
            $display("FAIL resync_slot: got %0d want 0", bus.slot_idx);
        end
        send_frame(32'h12345678, 1'b0);
        e = pop_exp();
        vectors++;
        if (bus.q !== e || bus.q_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL resync_frame: q=%h qv=%b, want q=%h qv=1", bus.q, bus.q_valid, e);
        end
    endtask

    task automatic test_resync_hold();
        logic [31:0] dropped;
        send_frame(32'hABCDEF09, 1'b0);
        vectors++;
        if (bus.din_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rh_enter_hold: rdy=%b want 0", bus.din_ready);
        end
        bus.resync = 1'b1; cyc(); bus.resync = 1'b0;
        dropped = exp_q.pop_back();
        vectors++;
        if (bus.frame_drop !== 1'b1 || bus.q !== 32'h87654321 || bus.q_valid !== 1'b1 ||
            bus.slot_idx !== 3'd0 || bus.din_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rh_drop: drop=%b q=%h qv=%b slot=%0d rdy=%b, want 1/87654321/1/0/1 (dropped %h)",
                     bus.frame_drop, bus.q, bus.q_valid, bus.slot_idx, bus.din_ready, dropped);
        end
        cyc();
        vectors++;
        if (bus.frame_drop !== 1'b0) begin
            miscompares++;
            $display("FAIL rh_drop_pulse: got %b want 0", bus.frame_drop);
        end
        bus.q_ack = 1'b1; cyc(); bus.q_ack = 1'b0;
        vectors++;
        if (bus.q_valid !== 1'b0 || bus.q !== 32'h87654321) begin
            miscompares++;
            $display("FAIL rh_ack: qv=%b q=%h, want qv=0 q=87654321", bus.q_valid, bus.q);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] e;
        for (int i = 0; i < 5; i++) begin
            bus.din = 4'hC; bus.din_valid = 1'b1; cyc();
        end
        bus.din_valid = 1'b0;
        reset = 1'b1; cyc();
        vectors++;
        if (bus.q !== 32'h0 || bus.q_valid !== 1'b0 || bus.slot_idx !== 3'd0 || bus.din_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rmid_reset: q=%h qv=%b slot=%0d rdy=%b, want 0/0/0/0",
                     bus.q, bus.q_valid, bus.slot_idx, bus.din_ready);
        end
        reset = 1'b0;
        send_frame(32'h2468ACEF, 1'b0);
        e = pop_exp();
        vectors++;
        if (bus.q !== e || bus.q_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL rmid_frame: q=%h qv=%b, want q=%h qv=1", bus.q, bus.q_valid, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        // Bank holds FECA8642; next frame completes with a same-cycle ack.
        send_frame(32'h0F1E2D3C, 1'b1);
        e = pop_exp();
        vectors++;
        if (bus.q !== e || bus.q_valid !== 1'b1 || bus.din_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_frame: q=%h qv=%b rdy=%b, want q=%h qv=1 rdy=1",
                     bus.q, bus.q_valid, bus.din_ready, e);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.din = '0; bus.din_valid = 1'b0; bus.resync = 1'b0; bus.q_ack = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_simultaneous();
        test_resync_mid();
        test_resync_hold();
        test_reset_mid();
        test_back_to_back();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/demux8_nibble_collector.md
Name: demux8_nibble_collector

Overview:
- Inverse of the team's 8:1 nibble multiplexer path.
- Takes a time-multiplexed stream of 4-bit nibbles on one bus and distributes them, in arrival order, into 8 slots.
- Presents each completed 8-slot frame as a parallel, double-buffered output bank with a valid/ack handshake.
- Sits at the receive end of any link that serialises eight nibble channels through the mux tree.

Parameters:
- WIDTH, 4, bits per nibble/slot.
- CHANNELS, 8, slots per frame; must be a power of two ≥2.
- PTR_W, 3, slot pointer width; equals log2(CHANNELS).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- din  input  WIDTH  incoming nibble.
- din_valid  input  1  din holds a nibble this cycle.
- din_ready  output  1  block can accept a nibble this cycle.
- resync  input  1  discard the partial frame; next accepted nibble is slot 0.
- slot_idx  output  PTR_W  slot the next accepted nibble will fill.
- q  output  CHANNELS*WIDTH  output bank; slot i at q[WIDTH*i +: WIDTH].
- q_valid  output  1  q holds an unconsumed frame.
- q_ack  input  1  consumer takes the frame; meaningful only while q_valid=1.
- frame_drop  output  1  one-cycle pulse when a pending full frame is discarded by resync.

Behaviour:
- Accept: din_valid && din_ready on the same cycle.
- Reset (reset=1 at an edge):
  - q=0, q_valid=0, slot_idx=0, frame_drop=0, shadow registers=0, state=COLLECT.
  - din_ready is forced 0 while reset is high.
  - Reset mid-frame discards all partial and pending data.
- States:
  - COLLECT: din_ready=1.
  - HOLD: shadow full, output bank occupied; din_ready=0.
- COLLECT, accept at slot k<CHANNELS-1: shadow[k]<=din, slot_idx<=k+1.
- COLLECT, accept at slot CHANNELS-1: slot_idx wraps to 0.
  - If bank free (q_valid=0, or q_valid=1 && q_ack=1 this cycle): next cycle q = {din, shadow[CHANNELS-2:0]}, q_valid=1, stay COLLECT.
  - Latency: q valid exactly 1 cycle after the final nibble is accepted.
  - Otherwise: shadow[CHANNELS-1]<=din, go to HOLD.
- HOLD: when q_ack=1, copy all shadow slots to q, q_valid stays 1, go to COLLECT. din_ready rises the following cycle.
- q_ack with no frame transfer: q_valid<=0, q unchanged. q_ack while q_valid=0 is ignored.
- Simultaneous q_ack and final-nibble accept: old frame is consumed and the new frame loaded in the same edge; q_valid stays 1.
- resync in COLLECT: slot_idx<=0, partial shadow contents irrelevant. A nibble offered that cycle is not stored (resync has priority), but din_ready still reads 1 and the source treats it as consumed.
- resync in HOLD: pending frame discarded, frame_drop=1 for one cycle, go to COLLECT, slot_idx=0. Output bank and q_valid are unaffected.
- resync and q_ack together in HOLD: resync wins, so no transfer; q_ack still clears q_valid.
- q and q_valid are registered outputs. din_ready is a combinational decode of state and reset only, with no path from din_valid.
- Throughput: one nibble per cycle sustained while the consumer acks each frame within CHANNELS cycles.

Decomposition:
- Shared package demux_pkg:
  - WIDTH and CHANNELS defaults.
  - State enum: COLLECT, HOLD.
  - Slot-packing helper constant for the q slice offset.
- One sub-module: slot_bank (CHANNELS×WIDTH register array with indexed write and parallel read), used for the shadow bank.
- The output bank and FSM stay in the top module.

Test Plan:
1. Basic frame: reset, then nibbles 0x1..0x8 on consecutive cycles with q_ack=0.
   - Required: q=0x87654321 one cycle after 0x8 is accepted, q_valid=1, slot_idx back to 0.
2. Backpressure: with q_valid=1 unacked, stream 0xA..0xF,0x0,0x9.
   - Required: din_ready=0 after the 8th nibble (HOLD).
   - Then q_ack=1 for one cycle: q=0x90FEDCBA, q_valid stays 1, din_ready=1 on the next cycle.
3. Simultaneous: final nibble 0x3 accepted on the same cycle as q_ack, shadow holding 0x1111111.
   - Required: next cycle q=0x31111111, q_valid=1, no HOLD entry.
4. Resync mid-frame: after 3 nibbles, assert resync together with nibble 0x5, then send 0x1..0x8.
   - Required: 0x5 not stored, q=0x87654321.
5. Resync in HOLD: enter HOLD as in scenario 2, then assert resync.
   - Required: frame_drop pulses for 1 cycle, old q and q_valid unchanged, a subsequent q_ack clears q_valid without loading a frame.
6. Reset mid-frame: assert reset after 5 nibbles.
   - Required: q=0, q_valid=0, slot_idx=0, din_ready=0 during reset; next 8 nibbles form a clean frame.
